// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice:
// FSM state type, register-index width and the default multiply/divide
// stall length.
package hazard_pkg;

    localparam int REG_W                 = 5;
    localparam int MULDIV_CYCLES_DEFAULT = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } hazard_state_t;

    // True when a producer register rd is a non-zero source of the ID
    // instruction (src_b only counts when the instruction actually reads it).
    function automatic logic reg_match(
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src_a,
        input logic [REG_W-1:0] src_b,
        input logic             use_b
    );
        return (rd != '0) && ((rd == src_a) || (use_b && (rd == src_b)));
    endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating 32-bit event counter used to count cycles in which the PC is
// held. Sticks at all-ones instead of wrapping.
module stall_perf_counter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Inc,
    output logic [31:0] Count
);

    // Count qualifying cycles, clear on synchronous reset, hold at maximum.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count <= '0;
        end else if (Inc && (Count != 32'hFFFF_FFFF)) begin
            Count <= Count + 32'd1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard and stall controller.
// - RUN/MDWAIT FSM freezes the front end for MULDIV_CYCLES cycles per
//   multiply/divide.
// - In RUN, a taken branch flushes IF/ID and ID/EX; otherwise a data hazard
//   holds PC and IF/ID and injects a bubble into ID/EX.
// - Build macro HAZARD_FWD_EN: defined means a forwarding datapath exists,
//   so only load-use stalls; undefined means any in-flight write to a
//   source register stalls.
// Control outputs are combinational so they settle before the PC loads.
// Handshake note: there is no valid/ready pair here; every input is a
// per-cycle level sampled on the rising edge of Clk (MulDivStart is a
// single-cycle pulse and is ignored while a wait is in progress).
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [REG_W-1:0]    IFID_Rs,
    input  logic [REG_W-1:0]    IFID_Rt,
    input  logic                IFID_UsesRt,
    input  logic                IDEX_MemRead,
    input  logic                IDEX_RegWrite,
    input  logic [REG_W-1:0]    IDEX_Rd,
    input  logic                EXMEM_RegWrite,
    input  logic [REG_W-1:0]    EXMEM_Rd,
    input  logic                BranchTaken,
    input  logic                MulDivStart,
    output logic                PCWrite,
    output logic                IFIDWrite,
    output logic                IFIDFlush,
    output logic                IDEXFlush,
    output logic                Busy,
    output logic [31:0]         StallCycles,
    output hazard_state_t       DbgState
);

    localparam int              CNT_W   = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    hazard_state_t    state;
    logic [CNT_W-1:0] MdCnt;
    logic             load_use;
    logic             data_hazard;

    assign DbgState = state;

    // Multi-cycle wait FSM: load the down-counter on a mult/div start and
    // return to RUN after the cycle in which it reads zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_RUN;
            MdCnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (MulDivStart) begin
                        state <= ST_MDWAIT;
                        MdCnt <= MD_LOAD;
                    end
                end
                ST_MDWAIT: begin
                    if (MdCnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        MdCnt <= MdCnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    MdCnt <= '0;
                end
            endcase
        end
    end

    // Data hazard detection; register 0 never matches (see reg_match).
    always_comb begin
        load_use = IDEX_MemRead && reg_match(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt);
`ifdef HAZARD_FWD_EN
        data_hazard = load_use;
`else
        data_hazard = load_use
                   || (IDEX_RegWrite  && reg_match(IDEX_Rd,  IFID_Rs, IFID_Rt, IFID_UsesRt))
                   || (EXMEM_RegWrite && reg_match(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_UsesRt));
`endif
    end

`ifdef HAZARD_FWD_EN
    // Producer write-enables are irrelevant when results are forwarded.
    logic unused_fwd;
    assign unused_fwd = ^{IDEX_RegWrite, EXMEM_RegWrite, EXMEM_Rd};
`endif

    // Pipeline control: reset > MDWAIT > branch > data hazard > free run.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        Busy      = 1'b0;
        if (!Reset) begin
            if (state == ST_MDWAIT) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
                Busy      = 1'b1;
            end else if (BranchTaken) begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end else if (data_hazard) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end
        end
    end

    stall_perf_counter u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (~PCWrite),
        .Count (StallCycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: reference model, stimulus
// table, directed multi-cycle sequences and a randomized run.
// Honours HAZARD_FWD_EN the same way as the design.
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  localparam int MD = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [4:0] rs, rt, idex_rd, exmem_rd;
  logic uses_rt, memread, idex_rw, exmem_rw, branch, mds;
  logic pcw, ifidw, ifidf, idexf, busy;
  logic [31:0] stall_cycles;
  hazard_state_t dbg_state;

  hazard_stall_unit #(.MULDIV_CYCLES(MD)) dut (
    .Clk            (clk),
    .Reset          (reset),
    .IFID_Rs        (rs),
    .IFID_Rt        (rt),
    .IFID_UsesRt    (uses_rt),
    .IDEX_MemRead   (memread),
    .IDEX_RegWrite  (idex_rw),
    .IDEX_Rd        (idex_rd),
    .EXMEM_RegWrite (exmem_rw),
    .EXMEM_Rd       (exmem_rd),
    .BranchTaken    (branch),
    .MulDivStart    (mds),
    .PCWrite        (pcw),
    .IFIDWrite      (ifidw),
    .IFIDFlush      (ifidf),
    .IDEXFlush      (idexf),
    .Busy           (busy),
    .StallCycles    (stall_cycles),
    .DbgState       (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  int busy_left = 0;          // remaining frozen cycles, including current
  logic [31:0] m_stall = '0;  // expected stall-cycle count

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic reads(input logic [4:0] r);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Busy} expected this cycle
  function automatic logic [4:0] model_out();
    logic hz;
    if (reset) return 5'b11000;
    if (busy_left > 0) return 5'b00011;
    if (branch) return 5'b11110;
    hz = memread && reads(idex_rd);
    if (!FWD_EN) hz = hz || (idex_rw && reads(idex_rd)) || (exmem_rw && reads(exmem_rd));
    if (hz) return 5'b00010;
    return 5'b11000;
  endfunction

  // Check one cycle against the model, then advance model across the edge.
  // Entered and left at posedge+1 with inputs already applied.
  task automatic tick(input string tag);
    logic [4:0] e;
    #1;
    e = model_out();
    chk({tag, ".pcwrite"}, pcw, e[4]);
    chk({tag, ".ifidwrite"}, ifidw, e[3]);
    chk({tag, ".ifidflush"}, ifidf, e[2]);
    chk({tag, ".idexflush"}, idexf, e[1]);
    chk({tag, ".busy"}, busy, e[0]);
    chk({tag, ".stallcycles"}, stall_cycles, m_stall);
    chk({tag, ".state_mdwait"}, dbg_state == ST_MDWAIT, busy_left > 0);
    @(posedge clk);
    if (reset) begin
      busy_left = 0;
      m_stall = '0;
    end else begin
      if (!e[4] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (busy_left > 0) busy_left--;
      else if (mds) busy_left = MD;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rs = '0; rt = '0; uses_rt = 0; memread = 0; idex_rw = 0;
    idex_rd = '0; exmem_rw = 0; exmem_rd = '0; branch = 0; mds = 0;
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread, idex_rw;
    logic [4:0] idex_rd;
    logic       exmem_rw;
    logic [4:0] exmem_rd;
    logic       branch;
    logic [3:0] exp_nofwd;  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}
    logic [3:0] exp_fwd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int busy_seen, pcw_low;
    logic [31:0] base;
    logic [3:0] texp;

    vecs[0] = '{5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0001}; // load-use Rs
    vecs[1] = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'b1100, 4'b1100}; // r0
    vecs[2] = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b0001}; // load-use Rt
    vecs[3] = '{5'd3, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 4'b1100, 4'b1100}; // Rt unused
    vecs[4] = '{5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b1, 4'b1111, 4'b1111}; // branch+LU
    vecs[5] = '{5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'b1111, 4'b1111}; // branch
    vecs[6] = '{5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 4'b0001, 4'b1100}; // EXMEM Rt
    vecs[7] = '{5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 4'b0001, 4'b1100}; // IDEX Rs
    vecs[8] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 4'b1100, 4'b1100}; // EXMEM r0
    vecs[9] = '{5'd4, 5'd6, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd3, 1'b0, 4'b1100, 4'b1100}; // no match

    // Reset
    idle_inputs();
    reset = 1'b1;
    memread = 1'b1; idex_rd = 5'd8; rs = 5'd8; mds = 1'b1;  // must be ignored
    @(posedge clk); #1;
    tick("reset_hold");
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("reset.stallcycles", stall_cycles, 32'd0);
    chk("reset.busy", busy, 1'b0);
    tick("post_reset");

    // Load-use stalls exactly one cycle and counts it
    memread = 1'b1; idex_rd = 5'd8; rs = 5'd8;
    #1;
    chk("loaduse.pcwrite", pcw, 1'b0);
    chk("loaduse.idexflush", idexf, 1'b1);
    tick("loaduse");
    idle_inputs();
    #1;
    chk("loaduse.count", stall_cycles, 32'd1);
    chk("loaduse.release", pcw, 1'b1);
    tick("loaduse_after");

    // Table
    for (int i = 0; i < 10; i++) begin
      rs = vecs[i].rs; rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
      memread = vecs[i].memread; idex_rw = vecs[i].idex_rw; idex_rd = vecs[i].idex_rd;
      exmem_rw = vecs[i].exmem_rw; exmem_rd = vecs[i].exmem_rd;
      branch = vecs[i].branch; mds = 1'b0;
      texp = FWD_EN ? vecs[i].exp_fwd : vecs[i].exp_nofwd;
      #1;
      chk($sformatf("vec%0d.ctrl", i), {pcw, ifidw, ifidf, idexf}, texp);
      tick($sformatf("vec%0d", i));
    end

    // Mul/div: exactly MD frozen cycles, second pulse mid-wait ignored
    idle_inputs();
    base = m_stall;
    mds = 1'b1;
    tick("md_start");
    busy_seen = 0; pcw_low = 0;
    for (int i = 0; i < 2 * MD; i++) begin
      mds = (i == 1);
      #1;
      if (busy) busy_seen++;
      if (!pcw) pcw_low++;
      tick($sformatf("md_wait%0d", i));
    end
    chk("md.busy_cycles", busy_seen, MD);
    chk("md.pcwrite_low_cycles", pcw_low, MD);
    chk("md.stallcycles", stall_cycles, base + MD);

    // Branch and MulDivStart together: branch now, wait next cycle
    idle_inputs();
    branch = 1'b1; mds = 1'b1; memread = 1'b1; idex_rd = 5'd8; rs = 5'd8;
    #1;
    chk("br_md.ifidflush", ifidf, 1'b1);
    chk("br_md.pcwrite", pcw, 1'b1);
    tick("br_md");
    idle_inputs();
    #1;
    chk("br_md.busy_next", busy, 1'b1);
    for (int i = 0; i < MD; i++) tick($sformatf("br_md_wait%0d", i));

    // Branch with load-use match, no mul/div
    branch = 1'b1; memread = 1'b1; idex_rd = 5'd8; rs = 5'd8;
    #1;
    chk("br_lu.flushes", {ifidf, idexf, pcw}, 3'b111);
    tick("br_lu");
    idle_inputs();

    // Reset at the second MDWAIT cycle aborts the wait
    mds = 1'b1;
    tick("mw_start");
    mds = 1'b0;
    tick("mw_cyc1");
    reset = 1'b1;
    tick("mw_cyc2_reset");
    reset = 1'b0;
    #1;
    chk("mw_reset.busy", busy, 1'b0);
    chk("mw_reset.stallcycles", stall_cycles, 32'd0);
    chk("mw_reset.pcwrite", pcw, 1'b1);
    tick("mw_after");

    // Forwarding-dependent case from the requirements list
    uses_rt = 1'b1; rt = 5'd5; exmem_rw = 1'b1; exmem_rd = 5'd5;
    #1;
    chk("exmem_rt.pcwrite", pcw, FWD_EN ? 1'b1 : 1'b0);
    tick("exmem_rt");
    idle_inputs();

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      uses_rt = 1'($urandom_range(0, 1));
      memread = ($urandom_range(0, 2) == 0);
      idex_rw = 1'($urandom_range(0, 1));
      idex_rd = 5'($urandom_range(0, 7));
      exmem_rw = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 7));
      branch = ($urandom_range(0, 5) == 0);
      mds = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      tick($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
